// File: rtl/uart_tx_arbiter.sv
// Round-robin, packet-granular sharing of one UART TX byte stream through a one-entry output register.
// Optional build macro UART_TX_TAG_EN: emit a tag byte (8'hA0 | grant_id) ahead of every grant.
module uart_tx_arbiter #(
    parameter int NREQ       = 4,
    parameter int DATA_WIDTH = 8,
    parameter int MAX_BURST  = 64
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [NREQ-1:0]            req_valid,
    output logic [NREQ-1:0]            req_ready,
    input  logic [NREQ*DATA_WIDTH-1:0] req_bits,
    input  logic [NREQ-1:0]            req_last,
    output logic                       serial_out_valid,
    input  logic                       serial_out_ready,
    output logic [DATA_WIDTH-1:0]      serial_out_bits,
    output logic [$clog2(NREQ)-1:0]    grant_id,
    output logic                       busy
);
    localparam int GW = $clog2(NREQ);
    localparam int CW = $clog2(MAX_BURST + 1);
    localparam logic [CW-1:0] BURST_END = CW'(MAX_BURST - 1);

`ifdef UART_TX_TAG_EN
    typedef enum logic [1:0] {IDLE = 2'd0, HDR = 2'd1, XFER = 2'd2} state_t;
    localparam logic [7:0] TAG_BASE = 8'hA0;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, XFER = 2'd2} state_t;
`endif

    state_t                state_q, state_d;
    logic [GW-1:0]         grant_q, grant_d;
    logic [GW-1:0]         rr_q, rr_d;
    logic [CW-1:0]         count_q, count_d;
    logic                  out_valid_q, out_valid_d;
    logic [DATA_WIDTH-1:0] out_bits_q, out_bits_d;
    logic                  load_en_s;
    logic [DATA_WIDTH-1:0] req_byte_s [NREQ];

    // First asserted requester strictly after the last winner, wrapping around.
    function automatic logic [GW-1:0] rr_pick(input logic [NREQ-1:0] v, input logic [GW-1:0] last);
        logic [GW-1:0] pick;
        logic [GW-1:0] cand;
        logic          found;
        pick  = last;
        found = 1'b0;
        for (int i = 1; i <= NREQ; i++) begin
            cand = GW'((int'(last) + i) % NREQ);
            if (!found && v[cand]) begin
                pick  = cand;
                found = 1'b1;
            end else begin
                found = found;
            end
        end
        return pick;
    endfunction

    for (genvar i = 0; i < NREQ; i++) begin : g_unpack
        assign req_byte_s[i] = req_bits[i*DATA_WIDTH +: DATA_WIDTH];
    end

    assign load_en_s        = !out_valid_q || serial_out_ready;
    assign serial_out_valid = out_valid_q;
    assign serial_out_bits  = out_bits_q;
    assign grant_id         = grant_q;
    assign busy             = (state_q != IDLE) || out_valid_q;

`ifdef UART_TX_TAG_EN
    logic [DATA_WIDTH-1:0] tag_s;
    assign tag_s = DATA_WIDTH'(TAG_BASE) | DATA_WIDTH'(grant_q);
`endif

    // Next-state, grant bookkeeping and output-register load decisions.
    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        rr_d        = rr_q;
        count_d     = count_q;
        out_bits_d  = out_bits_q;
        req_ready   = '0;
        // A drained register empties unless a new byte is loaded below.
        if (load_en_s) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end
        case (state_q)
            IDLE: begin
                if (|req_valid) begin
                    grant_d = rr_pick(req_valid, rr_q);
                    count_d = '0;
`ifdef UART_TX_TAG_EN
                    state_d = HDR;
`else
                    state_d = XFER;
`endif
                end else begin
                    state_d = IDLE;
                end
            end
`ifdef UART_TX_TAG_EN
            HDR: begin
                if (load_en_s) begin
                    out_bits_d  = tag_s;
                    out_valid_d = 1'b1;
                    state_d     = XFER;
                end else begin
                    state_d = HDR;
                end
            end
`endif
            XFER: begin
                req_ready[grant_q] = load_en_s;
                if (req_valid[grant_q] && load_en_s) begin
                    out_bits_d  = req_byte_s[grant_q];
                    out_valid_d = 1'b1;
                    count_d     = count_q + CW'(1);
                    if (req_last[grant_q] || (count_q == BURST_END)) begin
                        rr_d    = grant_q;
                        state_d = IDLE;
                    end else begin
                        state_d = XFER;
                    end
                end else begin
                    state_d = XFER;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers; reset discards any pending byte.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            grant_q     <= '0;
            rr_q        <= GW'(NREQ - 1);
            count_q     <= '0;
            out_valid_q <= 1'b0;
            out_bits_q  <= '0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            rr_q        <= rr_d;
            count_q     <= count_d;
            out_valid_q <= out_valid_d;
            out_bits_q  <= out_bits_d;
        end
    end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: directed phases plus random packets against a packet-level model.
// Build with UART_TX_TAG_EN defined to exercise the tag-byte variant.
module tb_uart_tx_arbiter;
    localparam int NREQ = 4;
    localparam int DW   = 8;
    localparam int MB   = 4;
`ifdef UART_TX_TAG_EN
    localparam int OVH  = 2;
`else
    localparam int OVH  = 1;
`endif

    logic            clock = 1'b0;
    logic            reset;
    logic [NREQ-1:0] req_valid, req_ready, req_last;
    logic [NREQ*DW-1:0] req_bits;
    logic            serial_out_valid, serial_out_ready;
    logic [DW-1:0]   serial_out_bits;
    logic [1:0]      grant_id;
    logic            busy;

    int tests = 0;
    int fails = 0;

    logic [8:0] mem [NREQ][64];
    int head [NREQ];
    int tail [NREQ];
    int exp_src [256];
    logic [DW-1:0] exp_out [512];
    int acc_n, out_n, acc_idx, out_idx;
    int m_rr;
    logic model_hung;
    int rdy_mode;
    int step_no;
    int last_acc_step;
    int s0;
    logic            obs_valid, obs_busy;
    logic [DW-1:0]   obs_bits;
    logic [NREQ-1:0] obs_ready;
    logic [1:0]      obs_grant;

    uart_tx_arbiter #(.NREQ(NREQ), .DATA_WIDTH(DW), .MAX_BURST(MB)) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_bits(req_bits), .req_last(req_last),
        .serial_out_valid(serial_out_valid), .serial_out_ready(serial_out_ready),
        .serial_out_bits(serial_out_bits), .grant_id(grant_id), .busy(busy)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic push(input int r, input logic [7:0] b, input logic l);
        mem[r][tail[r]] = {l, b};
        tail[r]++;
    endtask

    task automatic clear_queues();
        for (int i = 0; i < NREQ; i++) begin
            head[i] = 0;
            tail[i] = 0;
        end
    endtask

    // Packet-level reference: whole grants taken round-robin over non-empty requesters.
    task automatic build_model();
        int h [NREQ];
        int g, n;
        logic found, done;
        acc_n = 0; out_n = 0; acc_idx = 0; out_idx = 0; model_hung = 1'b0;
        for (int i = 0; i < NREQ; i++) h[i] = head[i];
        found = 1'b1;
        while (found && !model_hung) begin
            found = 1'b0;
            g = 0;
            for (int k = 1; k <= NREQ; k++) begin
                if (!found && h[(m_rr + k) % NREQ] != tail[(m_rr + k) % NREQ]) begin
                    g = (m_rr + k) % NREQ;
                    found = 1'b1;
                end
            end
            if (found) begin
`ifdef UART_TX_TAG_EN
                exp_out[out_n] = 8'hA0 | 8'(g);
                out_n++;
`endif
                n = 0;
                done = 1'b0;
                while (!done && h[g] != tail[g]) begin
                    exp_src[acc_n] = g;
                    acc_n++;
                    exp_out[out_n] = mem[g][h[g]][7:0];
                    out_n++;
                    n++;
                    done = mem[g][h[g]][8] || (n == MB);
                    h[g]++;
                end
                if (done) m_rr = g;
                else model_hung = 1'b1;
            end
        end
    endtask

    // One clock: drive at negedge, observe 1 time unit later, retire handshakes after posedge.
    task automatic step();
        logic [NREQ-1:0] hs;
        step_no++;
        for (int i = 0; i < NREQ; i++) begin
            req_valid[i]         = (head[i] != tail[i]);
            req_bits[i*DW +: DW] = req_valid[i] ? mem[i][head[i]][7:0] : 8'h00;
            req_last[i]          = req_valid[i] ? mem[i][head[i]][8] : 1'b0;
        end
        case (rdy_mode)
            0:       serial_out_ready = ($urandom_range(0, 3) != 0);
            1:       serial_out_ready = 1'b1;
            default: serial_out_ready = 1'b0;
        endcase
        #1;
        obs_valid = serial_out_valid;
        obs_bits  = serial_out_bits;
        obs_busy  = busy;
        obs_ready = req_ready;
        obs_grant = grant_id;
        hs = req_valid & req_ready;
        check("ready_onehot", 32'($countones(req_ready) <= 1), 32'd1);
        if (serial_out_valid && !serial_out_ready) check("stall_ready", 32'(req_ready), 32'd0);
        if (hs != '0) begin
            last_acc_step = step_no;
            if (acc_idx < acc_n) begin
                check("acc_src", 32'(hs), 32'd1 << exp_src[acc_idx]);
                acc_idx++;
            end else begin
                check("acc_extra", 32'(hs), 32'd0);
            end
        end
        if (serial_out_valid) begin
            if (out_idx < out_n) begin
                check("out_bits", 32'(serial_out_bits), 32'(exp_out[out_idx]));
                if (serial_out_ready) out_idx++;
            end else begin
                check("out_extra", 32'(serial_out_valid), 32'd0);
            end
        end
        @(posedge clock);
        for (int i = 0; i < NREQ; i++) if (hs[i]) head[i]++;
        @(negedge clock);
    endtask

    task automatic run_phase(input string tag, input int budget);
        int n;
        logic done_f;
        n = 0;
        done_f = 1'b0;
        while (!done_f && n < budget) begin
            step();
            n++;
            done_f = (acc_idx == acc_n) && (out_idx == out_n) && !obs_valid;
        end
        check({tag, "_done"}, 32'(done_f), 32'd1);
        check({tag, "_busy"}, 32'(obs_busy), 32'(model_hung));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        req_valid = '0; req_bits = '0; req_last = '0; serial_out_ready = 1'b0;
        rdy_mode = 1; step_no = 0; last_acc_step = 0; m_rr = NREQ - 1;
        clear_queues();
        build_model();
        repeat (2) @(posedge clock);
        @(negedge clock);
        #1;
        check("rst_valid", 32'(serial_out_valid), 32'd0);
        check("rst_bits", 32'(serial_out_bits), 32'd0);
        check("rst_ready", 32'(req_ready), 32'd0);
        check("rst_grant", 32'(grant_id), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        reset = 1'b0;

`ifndef UART_TX_TAG_EN
        push(0, 8'h11, 1'b0); push(0, 8'h22, 1'b0); push(0, 8'h33, 1'b1);
        build_model();
        step(); check("t1_arb_ready", 32'(obs_ready), 32'd0);
        step(); check("t1_ready", 32'(obs_ready), 32'd1);
        step(); check("t1_b0", 32'({obs_valid, obs_bits}), 32'h111);
        step(); check("t1_b1", 32'({obs_valid, obs_bits}), 32'h122);
        step(); check("t1_b2", 32'({obs_valid, obs_bits}), 32'h133);
        check("t1_busy_hold", 32'(obs_busy), 32'd1);
        step(); check("t1_valid_drop", 32'(obs_valid), 32'd0);
        check("t1_busy_drop", 32'(obs_busy), 32'd0);
        check("t1_grant", 32'(obs_grant), 32'd0);
`else
        push(2, 8'h55, 1'b1);
        build_model();
        step(); check("t6_arb_ready", 32'(obs_ready), 32'd0);
        step(); check("t6_hdr_ready", 32'(obs_ready), 32'd0);
        step(); check("t6_tag", 32'({obs_valid, obs_bits}), 32'h1A2);
        check("t6_ready", 32'(obs_ready), 32'h4);
        step(); check("t6_byte", 32'({obs_valid, obs_bits}), 32'h155);
        step(); check("t6_busy_drop", 32'(obs_busy), 32'd0);
        check("t6_grant", 32'(obs_grant), 32'd2);
`endif

        // Every requester queues two 2-byte packets; full-rate ready.
        for (int r = 0; r < NREQ; r++) begin
            for (int p = 0; p < 2; p++) begin
                push(r, 8'($urandom), 1'b0);
                push(r, 8'($urandom), 1'b1);
            end
        end
        build_model();
        rdy_mode = 1;
        s0 = step_no;
        run_phase("t2", 200);
        check("t2_cycles", 32'(last_acc_step - s0), 32'(8 * (2 + OVH)));

        // Back-pressure for five cycles in the middle of a packet.
        for (int b = 0; b < 4; b++) push(1, 8'(8'hC0 + b), 1'(b == 3));
        build_model();
        rdy_mode = 1;
        repeat (3) step();
        rdy_mode = 2;
        repeat (5) begin
            step();
            check("t3_stall_ready", 32'(obs_ready), 32'd0);
            check("t3_stall_valid", 32'(obs_valid), 32'd1);
        end
        rdy_mode = 1;
        run_phase("t3", 50);

        repeat (2) begin
            for (int r = 0; r < NREQ; r++) begin
                int npk;
                npk = $urandom_range(0, 3);
                for (int p = 0; p < npk; p++) begin
                    int len;
                    len = $urandom_range(1, 6);
                    for (int b = 0; b < len; b++) push(r, 8'($urandom), 1'(b == len - 1));
                end
            end
            build_model();
            rdy_mode = 0;
            run_phase("rnd", 600);
        end

        // Asynchronous reset in the middle of a packet.
        for (int b = 0; b < 5; b++) push(2, 8'(8'h70 + b), 1'(b == 4));
        build_model();
        rdy_mode = 1;
        repeat (3) step();
        #1 reset = 1'b1;
        #1;
        check("t5_rst_valid", 32'(serial_out_valid), 32'd0);
        check("t5_rst_ready", 32'(req_ready), 32'd0);
        check("t5_rst_busy", 32'(busy), 32'd0);
        @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        clear_queues();
        m_rr = NREQ - 1;
        push(0, 8'hA1, 1'b0); push(0, 8'hA2, 1'b1); push(3, 8'hB1, 1'b1);
        build_model();
        repeat (OVH + 1) step();
        check("t5_first_grant", 32'(obs_ready), 32'd1);
        run_phase("t5", 50);

        // Long packet without last: forced re-grant, then the grant is held.
        for (int b = 0; b < 6; b++) push(1, 8'(8'h10 + b), 1'b0);
        push(2, 8'h2F, 1'b1);
        build_model();
        rdy_mode = 0;
        run_phase("t4", 300);
        check("t4_grant_held", 32'(obs_grant), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
